lcd_spi_rx: RTL
===============

// Module: lcd_spi_rx
// PURPOSE
//  Responder end of the 4-wire LCD SPI link (cs/dc/sclk/mosi) that lcd_write drives.
//  Deserialises each SPI byte into a 9-bit {dc,byte} word.
//  Decodes the CASET, RASET and RAMWR commands to emit RGB565 pixels tagged with x/y.
//  Used as an on-chip loopback/panel model for checking lcd_init and lcd_show_pic.
// PARAMETERS
//  H_RES      320     panel width; reset value of x_end = H_RES-1
//  V_RES      240     panel height; reset value of y_end = V_RES-1
//  CMD_CASET  8'h2A   column-address-set opcode
//  CMD_RASET  8'h2B   row-address-set opcode
//  CMD_RAMWR  8'h2C   memory-write opcode
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous reset, active-high
//  spi_cs      in   1   chip select, active-low, asynchronous to clk
//  spi_dc      in   1   0=command, 1=data; sampled with bit 0 of each byte
//  spi_sclk    in   1   SPI clock, mode 0; data sampled on rising edge
//  spi_mosi    in   1   serial data, MSB first
//  word_valid  out  1   1-cycle pulse: word_data holds a complete byte
//  word_data   out  9   {dc, byte[7:0]}
//  pix_valid   out  1   1-cycle pulse: pix_data/pix_x/pix_y hold a pixel
//  pix_data    out  16  RGB565 pixel, first byte = [15:8]
//  pix_x       out  9   column of the pixel
//  pix_y       out  9   row of the pixel
//  frame_done  out  1   1-cycle pulse with the pixel at (x_end, y_end)
//  frame_err   out  1   1-cycle pulse: cs deasserted mid-byte
// BEHAVIOUR
//  - Reset: all outputs 0. FSM=IDLE, bit_cnt=0, x_start=y_start=0,
//    x_end=H_RES-1, y_end=V_RES-1.
//  - Input path: cs, dc, sclk and mosi each pass through a 2-flop synchroniser.
//    sclk rise is detected on the synchronised copy. sclk high and low times must each be >=3 clk.
//  - Shifter: while cs is low, each sclk rise shifts mosi into sr and increments bit_cnt (0..7).
//    On the 8th rise: word_data <= {dc, sr}, word_valid = 1 for one cycle, bit_cnt -> 0.
//    Latency is 4 clk from the pin sclk edge to word_valid.
//  - cs high forces bit_cnt = 0 and ignores sclk. If bit_cnt != 0 when cs rises:
//    frame_err pulses, the partial byte is dropped and the FSM is unchanged.
//  - Decoder FSM acts on word_valid only.
//    * A command word (dc=0) from any state aborts the current state.
//      CASET -> S_CASET; RASET -> S_RASET; RAMWR -> S_PIX_HI with x=x_start, y=y_start.
//      Any other opcode -> IDLE.
//    * S_CASET / S_RASET: 4 data bytes SH,SL,EH,EL go into a staging register (idx 0..3).
//      On the 4th byte, commit start={SH,SL}[8:0] and end={EH,EL}[8:0], then go to IDLE.
//      If a command arrives before the 4th byte, the staging register is discarded.
//    * S_PIX_HI: data byte -> hi reg, go to S_PIX_LO.
//    * S_PIX_LO: data byte -> pix_data={hi,byte}; pix_x=x, pix_y=y; pix_valid pulses 1 cycle
//      after the low byte's word_valid; go to S_PIX_HI.
//    * Data word in IDLE: ignored.
//  - Address advance after each pixel:
//    * x != x_end: x+1.
//    * x == x_end, y != y_end: x = x_start, y+1.
//    * x == x_end, y == y_end: frame_done pulses with that pixel; x = x_start, y = y_start.
//    * The FSM stays in RAMWR, so further data continues from the window start.
//  - start > end is not checked; the counters wrap mod 512 until they equal end.
//  - Synchronous rst mid-byte or mid-pixel returns everything to reset values.
//    The partial byte is lost and no pulses are emitted.
//  - An odd trailing byte at the end of RAMWR (a cs rise or a new command) is dropped without error.
// TESTING
//  1. Send cmd 0x2A as the 9-bit word 0_0010_1010 -> one word_valid, word_data=9'h02A, no pix_valid.
//  2. CASET 00,0A,00,0B; RASET 00,05,00,05; RAMWR; F8,00,07,E0
//     -> pix (10,5)=F800, then (11,5)=07E0 with frame_done.
//  3. Window 2x2 from (0,0), RAMWR + 5 pixels -> coordinates (0,0),(1,0),(0,1),(1,1),(0,0);
//     frame_done on the 4th pixel only.
//  4. cs rises after 5 bits -> frame_err pulse, no word_valid. The next full byte decodes correctly.
//  5. CASET with 2 bytes, then RAMWR + 1 pixel -> pixel at the old x_start (0); window unchanged.
//  6. Assert rst after the RAMWR high byte, then send low byte 0x55 -> no pix_valid;
//     x_end=319, y_end=239.

Source files
------------

// File: rtl/lcd_spi_rx.sv
// Responder end of the 4-wire LCD SPI link: deserialises {dc,byte} words and
// decodes CASET/RASET/RAMWR into RGB565 pixels tagged with their x/y address.
module lcd_spi_rx #(
    parameter int         H_RES     = 320,
    parameter int         V_RES     = 240,
    parameter logic [7:0] CMD_CASET = 8'h2A,
    parameter logic [7:0] CMD_RASET = 8'h2B,
    parameter logic [7:0] CMD_RAMWR = 8'h2C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_cs,
    input  logic        spi_dc,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        word_valid,
    output logic [8:0]  word_data,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        frame_done,
    output logic        frame_err
);

    typedef enum logic [2:0] {IDLE, S_CASET, S_RASET, S_PIX_HI, S_PIX_LO} state_t;

    state_t     state;
    logic [3:0] sclk_pipe;
    logic [2:0] cs_pipe, dc_pipe, mosi_pipe;
    logic [2:0] bit_cnt;
    logic [6:0] sr;
    logic [1:0] idx;
    logic [8:0] st_start;
    logic       st_eh;
    logic [7:0] hi;
    logic [8:0] x, y, x_start, x_end, y_start, y_end;
    logic       sclk_rise, cs_high;
    logic [8:0] new_end;

    // Stage 3 of each chain is the aligned view; sclk has one more flop for edge detect.
    assign sclk_rise = sclk_pipe[2] & ~sclk_pipe[3];
    assign cs_high   = cs_pipe[2];
    assign new_end   = {st_eh, word_data[7:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_pipe <= '0;
            cs_pipe   <= '1;
            dc_pipe   <= '0;
            mosi_pipe <= '0;
        end else begin
            sclk_pipe <= {sclk_pipe[2:0], spi_sclk};
            cs_pipe   <= {cs_pipe[1:0], spi_cs};
            dc_pipe   <= {dc_pipe[1:0], spi_dc};
            mosi_pipe <= {mosi_pipe[1:0], spi_mosi};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            sr         <= '0;
            word_valid <= 1'b0;
            word_data  <= '0;
            frame_err  <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (cs_high) begin
                bit_cnt <= '0;
                if (bit_cnt != 3'd0)
                    frame_err <= 1'b1;
            end else if (sclk_rise) begin
                sr <= {sr[5:0], mosi_pipe[2]};
                if (bit_cnt == 3'd7) begin
                    word_valid <= 1'b1;
                    word_data  <= {dc_pipe[2], sr, mosi_pipe[2]};
                    bit_cnt    <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            st_start   <= '0;
            st_eh      <= 1'b0;
            hi         <= '0;
            x          <= '0;
            y          <= '0;
            x_start    <= '0;
            y_start    <= '0;
            x_end      <= 9'(H_RES - 1);
            y_end      <= 9'(V_RES - 1);
            pix_valid  <= 1'b0;
            pix_data   <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            frame_done <= 1'b0;
        end else begin
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (word_valid) begin
                if (!word_data[8]) begin
                    idx <= '0;
                    case (word_data[7:0])
                        CMD_CASET: state <= S_CASET;
                        CMD_RASET: state <= S_RASET;
                        CMD_RAMWR: begin
                            state <= S_PIX_HI;
                            x     <= x_start;
                            y     <= y_start;
                        end
                        default:   state <= IDLE;
                    endcase
                end else begin
                    case (state)
                        S_CASET, S_RASET: begin
                            idx <= idx + 2'd1;
                            case (idx)
                                2'd0: st_start[8]   <= word_data[0];
                                2'd1: st_start[7:0] <= word_data[7:0];
                                2'd2: st_eh         <= word_data[0];
                                default: begin
                                    if (state == S_CASET) begin
                                        x_start <= st_start;
                                        x_end   <= new_end;
                                    end else begin
                                        y_start <= st_start;
                                        y_end   <= new_end;
                                    end
                                    state <= IDLE;
                                end
                            endcase
                        end
                        S_PIX_HI: begin
                            hi    <= word_data[7:0];
                            state <= S_PIX_LO;
                        end
                        S_PIX_LO: begin
                            pix_valid <= 1'b1;
                            pix_data  <= {hi, word_data[7:0]};
                            pix_x     <= x;
                            pix_y     <= y;
                            state     <= S_PIX_HI;
                            // Raster walk inside the window; counters wrap mod 512.
                            if (x != x_end) begin
                                x <= x + 9'd1;
                            end else if (y != y_end) begin
                                x <= x_start;
                                y <= y + 9'd1;
                            end else begin
                                x          <= x_start;
                                y          <= y_start;
                                frame_done <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
